ysyx_22040386_mdu_seq: RTL and testbench
========================================

// Module: ysyx_22040386_mdu_seq
// PURPOSE
//  Iterative RV64M multiply/divide sequencer in the EX stage, beside the single-cycle ALU.
//  Accepts one M-extension op from the ID/EX register and runs a radix-2 shift-add or
//  restoring-divide loop. Stalls the pipeline until the result is returned to the EX
//  write-back mux. Sequences all multi-cycle EX work; the ALU is untouched.
// PARAMETERS
//  XLEN  64  datapath width; word ops (i_word_op=1) use the low 32 bits
// PORTS
//  clk          in   1     clock, rising edge
//  rst_n        in   1     asynchronous active-low reset
//  i_valid      in   1     M-op present in EX; held stable by pipeline while o_stall=1
//  i_flush      in   1     synchronous kill (branch/jump redirect)
//  i_op         in   3     funct3: 000 MUL 001 MULH 010 MULHSU 011 MULHU 100 DIV 101 DIVU 110 REM 111 REMU
//  i_word_op    in   1     1 = *W variant (MULW/DIVW/DIVUW/REMW/REMUW)
//  i_src1       in   XLEN  forwarded rs1 value
//  i_src2       in   XLEN  forwarded rs2 value
//  o_stall      out  1     freeze IF/ID/EX; = i_valid & ~o_out_valid & ~i_flush
//  o_busy       out  1     state != IDLE
//  o_out_valid  out  1     one-cycle pulse, o_result valid
//  o_result     out  XLEN  registered result, held until next acceptance
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, count=0, o_out_valid=0, o_result=0, o_busy=0.
//  - FSM: IDLE -> CALC -> DONE -> IDLE.
//    IDLE: i_valid & ~i_flush at edge -> latch |operands|, signs, op, word_op; count=N -> CALC.
//      N=32 if i_word_op else XLEN. Operands for W: sign-ext (MULW/DIVW/REMW) or zero-ext
//      (DIVUW/REMUW) of bit 31..0.
//    CALC: one iteration per cycle; count decrements; at count==1 edge -> DONE with o_result
//      loaded (sign-corrected, W results sign-extended from bit 31).
//    DONE: o_out_valid=1, o_stall=0 (pipeline advances this edge); i_valid ignored; -> IDLE.
//  - Latency: i_valid first seen cycle 0 -> o_out_valid in cycle N+1; o_stall high cycles 0..N.
//  - Multiply: 2*XLEN accumulator on magnitudes; MUL/MULW low half, MULH*/MULHU high half.
//    MULHSU: src1 signed, src2 unsigned. MULH*/MULHU with i_word_op=1 give MULW result.
//  - Divide: restoring, unsigned magnitudes; quotient sign = s1^s2, remainder sign = s1.
//  - Special cases resolved at acceptance, CALC skipped (IDLE -> DONE, latency 1):
//      divisor 0: quotient = all ones, remainder = dividend (W: 32-bit rules, sign-ext).
//      signed overflow (MIN / -1): quotient = MIN, remainder = 0.
//  - i_flush: highest priority; in any state -> IDLE next edge, no o_out_valid, o_result kept.
//    Flush in the acceptance cycle: op not accepted.
//  - Back-to-back M-ops: next op accepted from IDLE only, earliest one cycle after DONE.
//  - Async reset mid-CALC: immediate IDLE, no pulse; stale o_result cleared to 0.
// CONFIGURATION
//  MDU_EARLY_OUT_EN defined: multiply with either operand 0, or divide with dividend 0
//    (divisor != 0), resolves at acceptance like special cases: IDLE -> DONE, result 0.
//  Undefined: these cases run the full N-cycle loop (result identical, latency N+1).
// TESTING
//  1 MUL 7*-3, XLEN ops -> o_out_valid at cycle 65, o_result=0xFFFF_FFFF_FFFF_FFEB, stall 0..64.
//  2 MULHU 0xFFFF_FFFF_FFFF_FFFF^2 -> 0xFFFF_FFFF_FFFF_FFFE; MULH -1*-1 -> 0.
//  3 DIVW src1=0x0000_0000_8000_0000, src2=-1 -> o_result=0xFFFF_FFFF_8000_0000 at cycle 1.
//  4 REMU 100 by 0 -> o_result=100 at cycle 1; DIV 100 by 0 -> all ones.
//  5 DIV -20/3 (q=-6), REM -20/3 (r=-2); REMW 0x1_0000_0007 by 2 -> 1 at cycle 33.
//  6 i_flush at cycle 10 of MUL -> IDLE at 11, no o_out_valid; new DIVU 9/2 accepted -> 4.

Source files
------------

// File: rtl/ysyx_22040386_mdu_seq_if.sv
// EX-stage M-extension sequencer bus.
// master = pipeline side, slave = MDU side.
interface ysyx_22040386_mdu_seq_if #(
  parameter int XLEN = 64
);
  logic            i_valid;
  logic            i_flush;
  logic [2:0]      i_op;
  logic            i_word_op;
  logic [XLEN-1:0] i_src1;
  logic [XLEN-1:0] i_src2;
  logic            o_stall;
  logic            o_busy;
  logic            o_out_valid;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_valid, i_flush, i_op, i_word_op,
    output i_src1, i_src2,
    input  o_stall, o_busy, o_out_valid, o_result
  );

  modport slave (
    input  i_valid, i_flush, i_op, i_word_op,
    input  i_src1, i_src2,
    output o_stall, o_busy, o_out_valid, o_result
  );
endinterface

// File: rtl/ysyx_22040386_mdu_seq.sv
// Iterative RV64M mul/div sequencer (radix-2 shift-add / restoring divide).
// Define MDU_EARLY_OUT_EN to resolve zero-operand ops at acceptance.
module ysyx_22040386_mdu_seq #(
  parameter int XLEN = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  ysyx_22040386_mdu_seq_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam int W2 = 2 * XLEN;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            word_q, word_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic [W2-1:0]   a_q, a_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] res_q, res_d;

  logic            is_mul, sdiv, sx;
  logic            sig1, sig2, s1, s2;
  logic            div0, ovf, early;
  logic [XLEN-1:0] x1, x2, m1, m2;
  logic [XLEN-1:0] min_v, spec_v;

  logic [W2-1:0]   prod_n, prod_c;
  logic [XLEN:0]   r_sh, diff;
  logic            qbit;
  logic [XLEN-1:0] q_n, r_n, q_c, r_c;
  logic [XLEN-1:0] fin_v;

  function automatic logic [XLEN-1:0] wfix(
    input logic [XLEN-1:0] v,
    input logic            w
  );
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  assign is_mul = ~bus.i_op[2];
  assign sdiv   = ~bus.i_op[0];
  assign sx     = is_mul | sdiv;

  // Operand extension, signedness and magnitudes of the incoming op
  always_comb begin
    x1 = bus.i_src1;
    x2 = bus.i_src2;
    if (bus.i_word_op) begin
      x1 = sx ? {{(XLEN-32){bus.i_src1[31]}}, bus.i_src1[31:0]}
              : {{(XLEN-32){1'b0}}, bus.i_src1[31:0]};
      x2 = sx ? {{(XLEN-32){bus.i_src2[31]}}, bus.i_src2[31:0]}
              : {{(XLEN-32){1'b0}}, bus.i_src2[31:0]};
    end
    if (bus.i_word_op) begin
      sig1 = sx;
      sig2 = sx;
    end else if (is_mul) begin
      sig1 = bus.i_op[1:0] != 2'b11;
      sig2 = ~bus.i_op[1];
    end else begin
      sig1 = sdiv;
      sig2 = sdiv;
    end
    s1 = sig1 & x1[XLEN-1];
    s2 = sig2 & x2[XLEN-1];
    m1 = s1 ? -x1 : x1;
    m2 = s2 ? -x2 : x2;
  end

  // Cases resolved at acceptance without running the loop
  always_comb begin
    min_v = bus.i_word_op ? {{(XLEN-31){1'b1}}, {31{1'b0}}}
                          : {1'b1, {(XLEN-1){1'b0}}};
    div0  = ~is_mul & (x2 == '0);
    ovf   = ~is_mul & sdiv & (x1 == min_v) & (x2 == {XLEN{1'b1}});
`ifdef MDU_EARLY_OUT_EN
    early = is_mul ? ((x1 == '0) | (x2 == '0))
                   : ((x1 == '0) & ~div0);
`else
    early = 1'b0;
`endif
    spec_v = '0;
    if (div0) begin
      spec_v = bus.i_op[1] ? x1 : {XLEN{1'b1}};
    end else if (ovf) begin
      spec_v = bus.i_op[1] ? '0 : min_v;
    end
  end

  // One shift-add / restoring step and the sign-corrected result
  always_comb begin
    prod_n = acc_q + (b_q[0] ? a_q : '0);
    prod_c = neg_q ? -prod_n : prod_n;
    r_sh   = {acc_q[XLEN-1:0], b_q[XLEN-1]};
    diff   = r_sh - {1'b0, a_q[XLEN-1:0]};
    qbit   = ~diff[XLEN];
    q_n    = {b_q[XLEN-2:0], qbit};
    r_n    = qbit ? diff[XLEN-1:0] : r_sh[XLEN-1:0];
    q_c    = neg_q ? -q_n : q_n;
    r_c    = rneg_q ? -r_n : r_n;
    if (~op_q[2]) begin
      fin_v = (op_q[1:0] == 2'b00 || word_q) ? prod_c[XLEN-1:0]
                                             : prod_c[W2-1:XLEN];
    end else begin
      fin_v = op_q[1] ? r_c : q_c;
    end
    fin_v = wfix(fin_v, word_q);
  end

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    word_d  = word_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    a_d     = a_q;
    acc_d   = acc_q;
    b_d     = b_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          op_d   = bus.i_op;
          word_d = bus.i_word_op;
          neg_d  = s1 ^ s2;
          rneg_d = s1;
          acc_d  = '0;
          if (div0 | ovf | early) begin
            res_d   = wfix(spec_v, bus.i_word_op);
            state_d = DONE;
          end else begin
            cnt_d   = bus.i_word_op ? CW'(32) : CW'(XLEN);
            state_d = CALC;
            if (is_mul) begin
              a_d = {{XLEN{1'b0}}, m1};
              b_d = m2;
            end else begin
              a_d = {{XLEN{1'b0}}, m2};
              b_d = bus.i_word_op ? {m1[31:0], {(XLEN-32){1'b0}}} : m1;
            end
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q - CW'(1);
        if (~op_q[2]) begin
          acc_d = prod_n;
          a_d   = a_q << 1;
          b_d   = b_q >> 1;
        end else begin
          acc_d = {{XLEN{1'b0}}, r_n};
          b_d   = q_n;
        end
        if (cnt_q == CW'(1)) begin
          res_d   = fin_v;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (bus.i_flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      res_d   = res_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      word_q  <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      a_q     <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      word_q  <= word_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign bus.o_busy      = state_q != IDLE;
  assign bus.o_out_valid = (state_q == DONE) & ~bus.i_flush;
  assign bus.o_stall     = bus.i_valid & ~bus.o_out_valid & ~bus.i_flush;
  assign bus.o_result    = res_q;
endmodule

// File: tb/tb_ysyx_22040386_mdu_seq.sv
// Scoreboard bench for the RV64M sequencer.
// Random and directed ops against an arithmetic reference model.
module tb_ysyx_22040386_mdu_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ysyx_22040386_mdu_seq_if #(.XLEN(64)) bus ();

  ysyx_22040386_mdu_seq #(.XLEN(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] last_res = 64'd0;

  function automatic logic [63:0] sext32(input logic [63:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  function automatic logic [63:0] dext(input logic [63:0] v,
                                       input logic w,
                                       input logic sg);
    if (!w) return v;
    return sg ? sext32(v) : {32'd0, v[31:0]};
  endfunction

  function automatic logic [63:0] model(input logic [2:0] op,
                                        input logic w,
                                        input logic [63:0] a,
                                        input logic [63:0] b);
    logic signed [127:0] sa, sb2;
    logic [127:0]        p;
    logic [63:0]         lo, r, q, rm, mn;
    logic signed [63:0]  da, db;
    logic                sg;
    if (!op[2]) begin
      lo = a * b;
      if (w) return sext32(lo);
      sa  = $signed(a);
      sb2 = $signed(b);
      case (op[1:0])
        2'b00: return lo;
        2'b01: p = sa * sb2;
        2'b10: p = sa * $signed({64'd0, b});
        default: p = {64'd0, a} * {64'd0, b};
      endcase
      return p[127:64];
    end
    sg = ~op[0];
    da = dext(a, w, sg);
    db = dext(b, w, sg);
    mn = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    if (db == 0) begin
      q  = '1;
      rm = da;
    end else if (sg && da == mn && db == -1) begin
      q  = mn;
      rm = 64'd0;
    end else if (sg) begin
      q  = da / db;
      rm = da % db;
    end else begin
      q  = $unsigned(da) / $unsigned(db);
      rm = $unsigned(da) % $unsigned(db);
    end
    r = op[1] ? rm : q;
    return w ? sext32(r) : r;
  endfunction

  function automatic int lat_of(input logic [2:0] op,
                                input logic w,
                                input logic [63:0] a,
                                input logic [63:0] b);
    logic [63:0] da, db, mn;
    logic        sg;
    if (op[2]) begin
      sg = ~op[0];
      da = dext(a, w, sg);
      db = dext(b, w, sg);
      mn = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
      if (db == 0) return 1;
      if (sg && da == mn && db == '1) return 1;
`ifdef MDU_EARLY_OUT_EN
      if (da == 0) return 1;
`endif
    end else begin
`ifdef MDU_EARLY_OUT_EN
      if (w && (a[31:0] == 0 || b[31:0] == 0)) return 1;
      if (!w && (a == 0 || b == 0)) return 1;
`endif
    end
    return w ? 33 : 65;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every result pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.o_out_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL spurious_out_valid: got 1 want 0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        if (bus.o_result !== e.res) begin
          n_bad++;
          $display("FAIL result: got %h want %h", bus.o_result, e.res);
        end
        n_cmp++;
        if (cyc - e.t0 != e.lat) begin
          n_bad++;
          $display("FAIL latency: got %0d want %0d", cyc - e.t0, e.lat);
        end
      end
    end
  end

  task automatic run_op(input logic [2:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b);
    exp_t e;
    bit   seen = 0;
    int   bad_st = 0;
    @(posedge clk);
    #1;
    bus.i_valid   = 1'b1;
    bus.i_op      = op;
    bus.i_word_op = w;
    bus.i_src1    = a;
    bus.i_src2    = b;
    e.res = model(op, w, a, b);
    e.lat = lat_of(op, w, a, b);
    e.t0  = cyc;
    sb.push_back(e);
    last_res = e.res;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (bus.o_stall !== !bus.o_out_valid) bad_st++;
      if (bus.o_out_valid) seen = 1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL timeout: got no out_valid want out_valid op %0d", op);
      void'(sb.pop_front());
    end
    chk("stall_profile_errors", 64'(bad_st), 64'd0);
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 20));
      4: return {$urandom, $urandom};
      default: return sext32({32'd0, $urandom});
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got hang want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.i_valid   = 1'b0;
    bus.i_flush   = 1'b0;
    bus.i_op      = 3'd0;
    bus.i_word_op = 1'b0;
    bus.i_src1    = 64'd0;
    bus.i_src2    = 64'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_out_valid", 64'(bus.o_out_valid), 64'd0);
    chk("rst_result", bus.o_result, 64'd0);
    rst_n = 1'b1;

    run_op(3'b000, 1'b0, 64'd7, -64'sd3);
    run_op(3'b011, 1'b0, '1, '1);
    run_op(3'b001, 1'b0, '1, '1);
    run_op(3'b100, 1'b1, 64'h0000_0000_8000_0000, '1);
    run_op(3'b111, 1'b0, 64'd100, 64'd0);
    run_op(3'b100, 1'b0, 64'd100, 64'd0);
    idle(2);
    run_op(3'b100, 1'b0, -64'sd20, 64'd3);
    run_op(3'b110, 1'b0, -64'sd20, 64'd3);
    run_op(3'b110, 1'b1, 64'h1_0000_0007, 64'd2);
    run_op(3'b010, 1'b0, '1, 64'd2);
    run_op(3'b100, 1'b0, 64'h8000_0000_0000_0000, '1);
    run_op(3'b111, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0);

    // Flush in cycle 10 of a MUL
    idle(1);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b1;
    bus.i_op    = 3'b000;
    bus.i_src1  = 64'd5;
    bus.i_src2  = 64'd9;
    repeat (10) @(posedge clk);
    #1;
    bus.i_flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", 64'(bus.o_stall), 64'd0);
    @(posedge clk);
    #1;
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(bus.o_busy), 64'd0);
    chk("flush_result_kept", bus.o_result, last_res);
    repeat (70) @(posedge clk);
    run_op(3'b101, 1'b0, 64'd9, 64'd2);

    for (int i = 0; i < 160; i++) begin
      run_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             pick(), pick());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Async reset in the middle of a divide
    idle(1);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b1;
    bus.i_op    = 3'b101;
    bus.i_src1  = 64'd12345;
    bus.i_src2  = 64'd7;
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(bus.o_busy), 64'd0);
    chk("arst_result", bus.o_result, 64'd0);
    bus.i_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    run_op(3'b101, 1'b0, 64'd9, 64'd2);
    idle(3);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
